// File: rtl/wb_packer.sv
// ============================================================================
// wb_packer : packs 16-bit engine results into BURST_LEN-lane words for DMA
// Revision  : 1.0
// ============================================================================
`default_nettype none

module wb_packer #(
  parameter int BURST_LEN = 8,
  parameter int DW        = 16,
  parameter int AW        = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [AW-1:0]           base_addr,
  input  logic                    output_en,
  input  logic [DW-1:0]           output_data,
  input  logic                    gemm_finish,
  output logic                    wr_en,
  input  logic                    wr_ready,
  output logic [AW-1:0]           wr_addr,
  output logic [DW*BURST_LEN-1:0] wr_data,
  output logic [BURST_LEN-1:0]    wr_mask,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [15:0]             word_count
);

  localparam int C_LW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [C_LW-1:0] C_LAST = C_LW'(BURST_LEN - 1);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_RUN   = 2'd1;
  localparam logic [1:0] C_FLUSH = 2'd2;
  localparam logic [1:0] C_DONE  = 2'd3;

  logic [1:0]                r_state;
  logic                      r_flush_first;
  logic [C_LW-1:0]           r_lane_cnt;
  logic [DW*BURST_LEN-1:0]   r_stage_data;
  logic [BURST_LEN-1:0]      r_stage_mask;
  logic [DW*BURST_LEN-1:0]   r_buf_data [2];
  logic [BURST_LEN-1:0]      r_buf_mask [2];
  logic                      r_rd_ptr;
  logic                      r_wr_ptr;
  logic [1:0]                r_count;
  logic [AW-1:0]             r_wr_addr;
  logic                      r_overflow;
  logic [15:0]               r_word_count;

  logic                      w_start;
  logic                      w_capture;
  logic                      w_commit_full;
  logic                      w_commit_part;
  logic                      w_commit;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_drop;
  logic [DW*BURST_LEN-1:0]   w_lane_data;
  logic [DW*BURST_LEN-1:0]   w_commit_data;
  logic [BURST_LEN-1:0]      w_commit_mask;

  assign w_start       = (r_state == C_IDLE) && start;
  assign w_capture     = (r_state == C_RUN) && output_en;
  assign w_commit_full = w_capture && (r_lane_cnt == C_LAST);
  assign w_commit_part = (r_state == C_FLUSH) && r_flush_first && (r_lane_cnt != '0);
  assign w_commit      = w_commit_full || w_commit_part;
  assign w_pop         = (r_count != 2'd0) && wr_ready;
  // A full buffer still accepts a word when the head leaves on the same edge.
  assign w_push        = w_commit && ((r_count != 2'd2) || w_pop);
  assign w_drop        = w_commit && !w_push;

  always_comb begin
    w_lane_data = r_stage_data;
    w_lane_data[int'(r_lane_cnt)*DW +: DW] = output_data;
  end

  assign w_commit_data = w_commit_full ? w_lane_data : r_stage_data;
  assign w_commit_mask = w_commit_full ? '1 : r_stage_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= C_IDLE;
      r_flush_first <= 1'b0;
    end else begin
      case (r_state)
        C_IDLE: if (start) r_state <= C_RUN;
        C_RUN: begin
          if (gemm_finish) begin
            r_state       <= C_FLUSH;
            r_flush_first <= 1'b1;
          end
        end
        C_FLUSH: begin
          r_flush_first <= 1'b0;
          if (!w_commit_part && (r_count == 2'd0)) r_state <= C_DONE;
        end
        default: r_state <= C_IDLE;
      endcase
    end
  end

  // Staging is cleared after every commit so a partial flush has zeroed lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane_cnt   <= '0;
      r_stage_data <= '0;
      r_stage_mask <= '0;
    end else if (w_start || w_commit_full || w_commit_part) begin
      r_lane_cnt   <= '0;
      r_stage_data <= '0;
      r_stage_mask <= '0;
    end else if (w_capture) begin
      r_lane_cnt               <= r_lane_cnt + 1'b1;
      r_stage_data             <= w_lane_data;
      r_stage_mask[r_lane_cnt] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
        r_buf_mask[i] <= '0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= w_commit_data;
        r_buf_mask[r_wr_ptr] <= w_commit_mask;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr    <= '0;
      r_overflow   <= 1'b0;
      r_word_count <= '0;
    end else if (w_start) begin
      r_wr_addr    <= base_addr;
      r_overflow   <= 1'b0;
      r_word_count <= '0;
    end else begin
      if (w_drop || (output_en && ((r_state == C_FLUSH) || (r_state == C_DONE))))
        r_overflow <= 1'b1;
      if (w_pop) begin
        r_wr_addr <= r_wr_addr + 1'b1;
        if (r_word_count != 16'hFFFF) r_word_count <= r_word_count + 16'd1;
      end
    end
  end

  assign wr_en      = (r_count != 2'd0);
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_buf_data[r_rd_ptr];
  assign wr_mask    = r_buf_mask[r_rd_ptr];
  assign busy       = (r_state == C_RUN) || (r_state == C_FLUSH);
  assign done       = (r_state == C_DONE);
  assign overflow   = r_overflow;
  assign word_count = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_wb_packer.sv
// ============================================================================
// tb_wb_packer : scoreboard bench for wb_packer against a queue-based model
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_wb_packer;

  localparam int BL = 8;
  localparam int DW = 16;
  localparam int AW = 10;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FLUSH = 2;
  localparam int M_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          output_en = 1'b0;
  logic [DW-1:0] output_data = '0;
  logic          gemm_finish = 1'b0;
  logic          wr_ready = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW*BL-1:0] wr_data;
  logic [BL-1:0] wr_mask;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [15:0]   word_count;

  wb_packer #(.BURST_LEN(BL), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .output_en(output_en), .output_data(output_data), .gemm_finish(gemm_finish),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .busy(busy), .done(done), .overflow(overflow),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [DW*BL-1:0] data;
    logic [BL-1:0]    mask;
  } word_t;

  word_t exp_q[$];
  int    ncmp = 0;
  int    nfail = 0;

  // Reference model: elements gathered in a queue, buffer tracked as an occupancy count.
  int            m_mode = M_IDLE;
  logic [DW-1:0] m_lanes[$];
  int            m_occ = 0;
  logic [AW-1:0] m_base = '0;
  int            m_pushed = 0;
  bit            m_ovf = 0;
  int            m_wc = 0;
  bit            m_first = 0;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic word_t pack_lanes();
    word_t w;
    w = '0;
    foreach (m_lanes[i]) begin
      w.data[i*DW +: DW] = m_lanes[i];
      w.mask[i] = 1'b1;
    end
    return w;
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_lanes.delete();
    m_occ = 0;
    m_base = '0;
    m_pushed = 0;
    m_ovf = 0;
    m_wc = 0;
    m_first = 0;
    exp_q.delete();
  endfunction

  function automatic void model_step();
    bit    pop;
    bit    have;
    word_t w;
    pop  = (m_occ > 0) && wr_ready;
    have = 0;
    w    = '0;
    case (m_mode)
      M_IDLE: begin
        if (start) begin
          m_mode = M_RUN; m_base = base_addr; m_pushed = 0;
          m_lanes.delete(); m_wc = 0; m_ovf = 0;
        end
      end
      M_RUN: begin
        if (output_en) begin
          m_lanes.push_back(output_data);
          if (m_lanes.size() == BL) begin
            have = 1; w = pack_lanes(); m_lanes.delete();
          end
        end
        if (gemm_finish) begin
          m_mode = M_FLUSH; m_first = 1;
        end
      end
      M_FLUSH: begin
        if (output_en) m_ovf = 1;
        if (m_first && m_lanes.size() > 0) begin
          have = 1; w = pack_lanes(); m_lanes.delete();
        end else if (m_occ == 0) begin
          m_mode = M_DONE;
        end
        m_first = 0;
      end
      default: begin
        if (output_en) m_ovf = 1;
        m_mode = M_IDLE;
      end
    endcase
    if (have) begin
      if (m_occ < 2 || pop) begin
        w.addr = m_base + AW'(m_pushed);
        m_pushed++;
        exp_q.push_back(w);
        m_occ++;
      end else begin
        m_ovf = 1;
      end
    end
    if (pop) begin
      m_occ--;
      if (m_wc < 65535) m_wc++;
    end
  endfunction

  always @(posedge clk) if (rst_n) model_step();

  // Monitor: compares status every cycle and the head word whenever wr_en is up.
  always @(negedge clk) begin
    chk("wr_en", wr_en, m_occ > 0);
    chk("busy", busy, (m_mode == M_RUN) || (m_mode == M_FLUSH));
    chk("done", done, m_mode == M_DONE);
    chk("overflow", overflow, m_ovf);
    chk("word_count", word_count, m_wc);
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        chk("wr_addr", wr_addr, exp_q[0].addr);
        chk("wr_data", wr_data, exp_q[0].data);
        chk("wr_mask", wr_mask, exp_q[0].mask);
        if (wr_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(bit st, bit en, logic [DW-1:0] d, bit fin, bit rdy,
                       logic [AW-1:0] base = '0);
    @(posedge clk);
    #2;
    start = st; output_en = en; output_data = d; gemm_finish = fin;
    wr_ready = rdy; base_addr = base;
  endtask

  task automatic idle(int n, bit rdy);
    repeat (n) drive(0, 0, '0, 0, rdy);
  endtask

  task automatic feed(int n, logic [DW-1:0] first, bit rdy);
    for (int i = 0; i < n; i++) drive(0, 1, first + DW'(i), 0, rdy);
  endtask

  task automatic wait_idle(int bound, bit rnd);
    int k;
    k = 0;
    while (m_mode != M_IDLE && k < bound) begin
      drive(0, rnd ? ($urandom_range(0, 7) == 0) : 1'b0, DW'($urandom),
            0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      k++;
    end
    if (m_mode != M_IDLE) chk("wait_idle_timeout", k, 0);
  endtask

  task automatic do_reset();
    start = 0; output_en = 0; gemm_finish = 0; wr_ready = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_mask", wr_mask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_word_count", word_count, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    int n;
    int sent;
    bit en;

    do_reset();
    idle(2, 1);

    // Single full word, then an empty flush
    drive(1, 0, '0, 0, 1, 10'h040);
    feed(8, 16'h3C00, 1);
    idle(3, 1);
    chk("word_count_first_word", word_count, 1);
    drive(0, 0, '0, 1, 1);
    wait_idle(20, 0);

    // Two full words plus a 3-lane partial on flush
    drive(1, 0, '0, 0, 1, 10'h100);
    feed(19, 16'h1000, 1);
    drive(0, 0, '0, 1, 1);
    wait_idle(40, 0);

    // Backpressure: two buffered, third dropped
    drive(1, 0, '0, 0, 0, 10'h200);
    feed(16, 16'h2000, 0);
    idle(3, 0);
    feed(8, 16'h2100, 0);
    idle(2, 0);
    chk("stall_word_count", word_count, 0);
    chk("stall_overflow", overflow, 1);
    drive(0, 0, '0, 1, 1);
    wait_idle(40, 0);

    // gemm_finish together with the 8th element
    drive(1, 0, '0, 0, 1, 10'h280);
    feed(7, 16'h5000, 1);
    drive(0, 1, 16'h5007, 1, 1);
    wait_idle(40, 0);

    // Address wrap
    drive(1, 0, '0, 0, 1, 10'h3FF);
    feed(16, 16'h6000, 1);
    drive(0, 0, '0, 1, 1);
    wait_idle(40, 0);

    // Randomized passes
    for (int p = 0; p < 12; p++) begin
      drive(1, 0, '0, 0, 1'($urandom_range(0, 1)), AW'($urandom));
      n = $urandom_range(0, 30);
      sent = 0;
      while (sent < n) begin
        en = ($urandom_range(0, 3) != 0);
        drive(0, en, DW'($urandom), 0, 1'($urandom_range(0, 1)));
        if (en) sent++;
      end
      drive(0, 1'($urandom_range(0, 1)), DW'($urandom), 1, 1'($urandom_range(0, 1)));
      wait_idle(200, 1);
      idle(2, 1);
    end

    // Reset mid-word, then a clean word
    drive(1, 0, '0, 0, 1, 10'h080);
    feed(5, 16'h7000, 1);
    do_reset();
    idle(1, 1);
    drive(1, 0, '0, 0, 1, 10'h090);
    feed(8, 16'hA000, 1);
    idle(2, 1);
    drive(0, 0, '0, 1, 1);
    wait_idle(40, 0);
    idle(3, 1);

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

`default_nettype wire
